// File: rtl/sample_fifo_pkg.sv
// Shared types and elaboration helpers for the sample FIFO.
package sample_fifo_pkg;

    // Read-side behaviour: registered read data or first-word-fall-through.
    typedef enum logic {
        FIFO_STANDARD = 1'b0,
        FIFO_FWFT     = 1'b1
    } fifo_mode_t;

    // True when n is a positive power of two.
    function automatic bit is_pow2(input int n);
        return (n > 32'sd0) && ((n & (n - 32'sd1)) == 32'sd0);
    endfunction

endpackage

// File: rtl/fifo_ram.sv
// Simple dual-port sample storage: synchronous write, asynchronous read, no reset.
module fifo_ram #(
    parameter int DATA_LENGTH  = 16,
    parameter int DEPTH_LENGTH = 16,
    parameter int DEPTH        = $clog2(DEPTH_LENGTH)
) (
    input  logic                   clk,
    input  logic                   i_wr_en,
    input  logic [DEPTH-1:0]       i_wr_addr,
    input  logic [DATA_LENGTH-1:0] i_wr_data,
    input  logic [DEPTH-1:0]       i_rd_addr,
    output logic [DATA_LENGTH-1:0] o_rd_data
);

    logic [DATA_LENGTH-1:0] r_mem [DEPTH_LENGTH];

    // Store the pushed word; contents are deliberately left unreset.
    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    assign o_rd_data = r_mem[i_rd_addr];

endmodule

// File: rtl/sample_fifo.sv
// Sample FIFO between the decimation filter chain and the readout logic.
// Owns pointers, status flags, sticky errors and the read-side output stage.
module sample_fifo
    import sample_fifo_pkg::*;
#(
    parameter int         DATA_LENGTH  = 16,
    parameter int         DEPTH_LENGTH = 16,
    parameter fifo_mode_t MODE         = FIFO_STANDARD,
    parameter int         DEPTH        = $clog2(DEPTH_LENGTH)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   clear,
    input  logic                   write,
    input  logic [DATA_LENGTH-1:0] i_data,
    input  logic                   read,
    output logic [DATA_LENGTH-1:0] o_data,
    output logic                   o_valid,
    output logic [DEPTH:0]         level,
    input  logic [DEPTH:0]         almost_full_level,
    input  logic [DEPTH:0]         almost_empty_level,
    output logic                   full,
    output logic                   empty,
    output logic                   almost_full,
    output logic                   almost_empty,
    output logic                   full_error,
    output logic                   empty_error
);

    typedef logic [DEPTH:0] ptr_t;

    localparam ptr_t L_FULL_LEVEL = ptr_t'(DEPTH_LENGTH);
    localparam ptr_t L_PTR_STEP   = ptr_t'(1);

    if (!is_pow2(DEPTH_LENGTH) || (DEPTH_LENGTH < 32'sd2)) begin : g_bad_depth
        $error("sample_fifo: DEPTH_LENGTH must be a power of two and at least 2");
    end

    ptr_t                   r_wr_ptr;
    ptr_t                   r_rd_ptr;
    ptr_t                   w_level;
    logic                   w_full;
    logic                   w_empty;
    logic                   w_rd_acc;
    logic                   w_wr_acc;
    logic                   r_full_error;
    logic                   r_empty_error;
    logic [DATA_LENGTH-1:0] w_rd_data;

    // Fill level and status flags straight from the registered pointers (no lag).
    always_comb begin
        w_level      = r_wr_ptr - r_rd_ptr;
        w_full       = (w_level == L_FULL_LEVEL);
        w_empty      = (w_level == '0);
        almost_full  = (w_level >= almost_full_level);
        almost_empty = (w_level <= almost_empty_level);
    end

    // Acceptance: no read on empty, a write at full only when a read frees a slot.
    always_comb begin
        w_rd_acc = read && !w_empty && !clear;
        w_wr_acc = write && (!w_full || w_rd_acc) && !clear;
    end

    // Pointer advance; clear takes priority over any push or pop that cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else if (clear) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_wr_acc) begin
                r_wr_ptr <= r_wr_ptr + L_PTR_STEP;
            end
            if (w_rd_acc) begin
                r_rd_ptr <= r_rd_ptr + L_PTR_STEP;
            end
        end
    end

    // Sticky overflow/underflow flags, released only by clear or reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_full_error  <= 1'b0;
            r_empty_error <= 1'b0;
        end else if (clear) begin
            r_full_error  <= 1'b0;
            r_empty_error <= 1'b0;
        end else begin
            r_full_error  <= r_full_error  | (write && !w_wr_acc);
            r_empty_error <= r_empty_error | (read && !w_rd_acc);
        end
    end

    fifo_ram #(
        .DATA_LENGTH (DATA_LENGTH),
        .DEPTH_LENGTH(DEPTH_LENGTH),
        .DEPTH       (DEPTH)
    ) u_ram (
        .clk      (clk),
        .i_wr_en  (w_wr_acc),
        .i_wr_addr(r_wr_ptr[DEPTH-1:0]),
        .i_wr_data(i_data),
        .i_rd_addr(r_rd_ptr[DEPTH-1:0]),
        .o_rd_data(w_rd_data)
    );

    if (MODE == FIFO_FWFT) begin : g_fwft
        // Head word shown directly; forced to zero while empty so stale memory never leaks.
        always_comb begin
            o_valid = !w_empty;
            o_data  = w_empty ? '0 : w_rd_data;
        end
    end else begin : g_std
        logic [DATA_LENGTH-1:0] r_data;
        logic                   r_valid;

        // Registered read port: data captured on an accepted pop, valid pulses one cycle.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_data  <= '0;
                r_valid <= 1'b0;
            end else if (clear) begin
                r_data  <= '0;
                r_valid <= 1'b0;
            end else begin
                r_valid <= w_rd_acc;
                if (w_rd_acc) begin
                    r_data <= w_rd_data;
                end
            end
        end

        assign o_data  = r_data;
        assign o_valid = r_valid;
    end

    assign level       = w_level;
    assign full        = w_full;
    assign empty       = w_empty;
    assign full_error  = r_full_error;
    assign empty_error = r_empty_error;

endmodule

// File: tb/tb_sample_fifo.sv
// Self-checking bench: a standard and an FWFT instance share stimulus and are
// compared every cycle against a queue-based reference model.
module tb_sample_fifo;
    import sample_fifo_pkg::*;

    localparam int DW = 16;
    localparam int DL = 4;
    localparam int D  = 2;

    logic          clk;
    logic          rst_n;
    logic          clear;
    logic          write;
    logic          read;
    logic [DW-1:0] i_data;
    logic [D:0]    afl;
    logic [D:0]    ael;

    logic [DW-1:0] s_odata, f_odata;
    logic          s_ovalid, f_ovalid;
    logic [D:0]    s_level, f_level;
    logic          s_full, s_empty, s_af, s_ae, s_ferr, s_eerr;
    logic          f_full, f_empty, f_af, f_ae, f_ferr, f_eerr;

    int total = 0;
    int bad   = 0;

    // reference model state
    logic [DW-1:0] q[$];
    bit            m_ferr, m_eerr, m_svalid;
    logic [DW-1:0] m_sdata;

    sample_fifo #(.DATA_LENGTH(DW), .DEPTH_LENGTH(DL), .MODE(FIFO_STANDARD)) u_std (
        .clk(clk), .rst_n(rst_n), .clear(clear), .write(write), .i_data(i_data),
        .read(read), .o_data(s_odata), .o_valid(s_ovalid), .level(s_level),
        .almost_full_level(afl), .almost_empty_level(ael),
        .full(s_full), .empty(s_empty), .almost_full(s_af), .almost_empty(s_ae),
        .full_error(s_ferr), .empty_error(s_eerr)
    );

    sample_fifo #(.DATA_LENGTH(DW), .DEPTH_LENGTH(DL), .MODE(FIFO_FWFT)) u_fwft (
        .clk(clk), .rst_n(rst_n), .clear(clear), .write(write), .i_data(i_data),
        .read(read), .o_data(f_odata), .o_valid(f_ovalid), .level(f_level),
        .almost_full_level(afl), .almost_empty_level(ael),
        .full(f_full), .empty(f_empty), .almost_full(f_af), .almost_empty(f_ae),
        .full_error(f_ferr), .empty_error(f_eerr)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_ferr   = 1'b0;
        m_eerr   = 1'b0;
        m_svalid = 1'b0;
        m_sdata  = '0;
    endtask

    // One clock edge of the FIFO behaviour, written from the acceptance rules.
    task automatic model_edge(input bit w, input logic [DW-1:0] d, input bit r, input bit c);
        int  sz;
        bit  rd_acc, wr_acc;
        if (c) begin
            model_reset();
        end else begin
            sz     = q.size();
            rd_acc = r && (sz > 0);
            wr_acc = w && ((sz < DL) || rd_acc);
            if (r && !rd_acc) m_eerr = 1'b1;
            if (w && !wr_acc) m_ferr = 1'b1;
            m_svalid = rd_acc;
            if (rd_acc) m_sdata = q.pop_front();
            if (wr_acc) q.push_back(d);
        end
    endtask

    task automatic check_all();
        int sz;
        sz = q.size();
        check_val("s_level", 32'(s_level), 32'(sz));
        check_val("f_level", 32'(f_level), 32'(sz));
        check_val("s_full",  32'(s_full),  32'(sz == DL));
        check_val("f_full",  32'(f_full),  32'(sz == DL));
        check_val("s_empty", 32'(s_empty), 32'(sz == 0));
        check_val("f_empty", 32'(f_empty), 32'(sz == 0));
        check_val("s_afull", 32'(s_af), 32'(sz >= int'(afl)));
        check_val("f_afull", 32'(f_af), 32'(sz >= int'(afl)));
        check_val("s_aempty", 32'(s_ae), 32'(sz <= int'(ael)));
        check_val("f_aempty", 32'(f_ae), 32'(sz <= int'(ael)));
        check_val("s_ferr", 32'(s_ferr), 32'(m_ferr));
        check_val("f_ferr", 32'(f_ferr), 32'(m_ferr));
        check_val("s_eerr", 32'(s_eerr), 32'(m_eerr));
        check_val("f_eerr", 32'(f_eerr), 32'(m_eerr));
        check_val("s_ovalid", 32'(s_ovalid), 32'(m_svalid));
        check_val("s_odata",  32'(s_odata),  32'(m_sdata));
        check_val("f_ovalid", 32'(f_ovalid), 32'(sz != 0));
        if (sz != 0) begin
            check_val("f_odata", 32'(f_odata), 32'(q[0]));
        end
    endtask

    task automatic step(input bit w, input logic [DW-1:0] d, input bit r, input bit c);
        write  = w;
        i_data = d;
        read   = r;
        clear  = c;
        @(posedge clk);
        model_edge(w, d, r, c);
        #1;
        check_all();
    endtask

    initial begin
        logic [DW-1:0] v;
        clk    = 1'b0;
        rst_n  = 1'b0;
        clear  = 1'b0;
        write  = 1'b0;
        read   = 1'b0;
        i_data = '0;
        afl    = 3'd4;
        ael    = 3'd0;
        model_reset();
        repeat (2) @(negedge clk);
        check_all();
        check_val("rst_s_odata", 32'(s_odata), 32'h0);
        check_val("rst_f_odata", 32'(f_odata), 32'h0);
        check_val("rst_f_ovalid", 32'(f_ovalid), 32'h0);
        rst_n = 1'b1;
        @(negedge clk);

        // fill to full, then one overflowing write
        for (int i = 1; i <= 5; i++) step(1'b1, 16'(i), 1'b0, 1'b0);
        check_val("fill_level", 32'(s_level), 32'd4);
        check_val("fill_ferr",  32'(s_ferr),  32'd1);

        // standard drain plus one underflowing read
        for (int i = 1; i <= 5; i++) step(1'b0, 16'h0, 1'b1, 1'b0);
        check_val("drain_hold", 32'(s_odata),  32'h0004);
        check_val("drain_vld",  32'(s_ovalid), 32'd0);
        check_val("drain_eerr", 32'(s_eerr),   32'd1);

        // full boundary: simultaneous write and read at level 4
        step(1'b0, 16'h0, 1'b0, 1'b1);
        for (int i = 1; i <= 4; i++) step(1'b1, 16'(16'h0010 + i), 1'b0, 1'b0);
        step(1'b1, 16'h00AA, 1'b1, 1'b0);
        check_val("bnd_level", 32'(s_level), 32'd4);
        check_val("bnd_ferr",  32'(s_ferr),  32'd0);
        for (int i = 0; i < 4; i++) step(1'b0, 16'h0, 1'b1, 1'b0);
        check_val("bnd_last", 32'(s_odata), 32'h00AA);

        // FWFT head word and drain
        step(1'b1, 16'h1234, 1'b0, 1'b0);
        check_val("fwft_vld",  32'(f_ovalid), 32'd1);
        check_val("fwft_data", 32'(f_odata),  32'h1234);
        step(1'b0, 16'h0, 1'b1, 1'b0);
        check_val("fwft_gone",  32'(f_ovalid), 32'd0);
        check_val("fwft_empty", 32'(f_empty),  32'd1);

        // thresholds
        afl = 3'd3;
        ael = 3'd1;
        for (int i = 0; i < 3; i++) step(1'b1, 16'($urandom), 1'b0, 1'b0);
        check_val("thr_af3", 32'(s_af), 32'd1);
        for (int i = 0; i < 3; i++) step(1'b0, 16'h0, 1'b1, 1'b0);
        check_val("thr_ae0", 32'(s_ae), 32'd1);

        // clear with errors set at level 2, together with a write
        step(1'b0, 16'h0, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) step(1'b1, 16'($urandom), 1'b0, 1'b0);
        step(1'b0, 16'h0, 1'b1, 1'b0);
        step(1'b0, 16'h0, 1'b1, 1'b0);
        check_val("pre_clr_lvl", 32'(s_level), 32'd2);
        step(1'b1, 16'h5555, 1'b0, 1'b1);
        check_val("clr_level", 32'(s_level), 32'd0);
        check_val("clr_ferr",  32'(f_ferr),  32'd0);
        check_val("clr_eerr",  32'(f_eerr),  32'd0);

        // asynchronous reset mid-cycle
        step(1'b1, 16'h0BEE, 1'b0, 1'b0);
        step(1'b1, 16'h0CAF, 1'b1, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check_all();
        check_val("arst_level", 32'(f_level), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // pointer wrap with data integrity
        for (int i = 0; i < 20; i++) begin
            v = 16'($urandom);
            step(1'b1, v, 1'b0, 1'b0);
            step(1'b0, 16'h0, 1'b1, 1'b0);
            check_val("wrap_data", 32'(s_odata), 32'(v));
        end

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            if ((i % 16) == 0) begin
                afl = 3'($urandom_range(0, 4));
                ael = 3'($urandom_range(0, 4));
            end
            step(1'($urandom), 16'($urandom), 1'($urandom), ($urandom_range(0, 31) == 0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
